// File: rtl/axi4_lite_pkg.sv
// Shared types for the AXI4-Lite register bank: response codes and FSM state encodings.
package axi4_lite_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_t;

  typedef enum logic [1:0] {
    W_IDLE,
    W_HAVE_ADDR,
    W_HAVE_DATA,
    W_RESP
  } wstate_t;

  typedef enum logic {
    R_IDLE,
    R_RESP
  } rstate_t;

  // Accesses outside the register window are answered with SLVERR.
  function automatic resp_t range_resp(input logic in_range);
    return in_range ? OKAY : SLVERR;
  endfunction

endpackage

// File: rtl/axi4_lite_addr_decode.sv
// Splits a byte address into a register index and an in-range flag.
module axi4_lite_addr_decode
  import axi4_lite_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_REGS   = 8
) (
  input  logic [ADDR_WIDTH-1:0]       i_addr,
  output logic [$clog2(NUM_REGS)-1:0] o_idx_c,
  output logic                        o_in_range_c
);

  localparam int unsigned OFF_W  = $clog2(DATA_WIDTH / 8);
  localparam int unsigned IDX_W  = $clog2(NUM_REGS);
  localparam int unsigned HI_LSB = OFF_W + IDX_W;

  // Byte-offset bits never select anything; they are folded away here.
  logic w_unused_off;
  assign w_unused_off = ^i_addr[OFF_W-1:0];

  assign o_idx_c      = i_addr[HI_LSB-1:OFF_W];
  assign o_in_range_c = (i_addr[ADDR_WIDTH-1:HI_LSB] == '0);

endmodule

// File: rtl/axi4_lite_regbank.sv
// AXI4-Lite slave register bank with independent write/read FSMs.
// Optional AXI4L_WSTRB_EN adds s_axi_wstrb byte-lane write enables.
module axi4_lite_regbank
  import axi4_lite_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned NUM_REGS   = 8
) (
  input  logic                           aclk,
  input  logic                           aresetn,
  input  logic [ADDR_WIDTH-1:0]          s_axi_awaddr,
  input  logic                           s_axi_awvalid,
  output logic                           s_axi_awready,
  input  logic [DATA_WIDTH-1:0]          s_axi_wdata,
`ifdef AXI4L_WSTRB_EN
  input  logic [DATA_WIDTH/8-1:0]        s_axi_wstrb,
`endif
  input  logic                           s_axi_wvalid,
  output logic                           s_axi_wready,
  output logic [1:0]                     s_axi_bresp,
  output logic                           s_axi_bvalid,
  input  logic                           s_axi_bready,
  input  logic [ADDR_WIDTH-1:0]          s_axi_araddr,
  input  logic                           s_axi_arvalid,
  output logic                           s_axi_arready,
  output logic [DATA_WIDTH-1:0]          s_axi_rdata,
  output logic [1:0]                     s_axi_rresp,
  output logic                           s_axi_rvalid,
  input  logic                           s_axi_rready,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out
);

  localparam int unsigned IDX_W  = $clog2(NUM_REGS);
  localparam int unsigned STRB_W = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];

  wstate_t               r_wstate;
  logic                  r_awready;
  logic                  r_wready;
  logic                  r_bvalid;
  resp_t                 r_bresp;
  logic [IDX_W-1:0]      r_aw_idx;
  logic                  r_aw_ok;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [STRB_W-1:0]     r_wstrb;

  rstate_t               r_rstate;
  logic                  r_arready;
  logic                  r_rvalid;
  resp_t                 r_rresp;
  logic [DATA_WIDTH-1:0] r_rdata;

  logic [IDX_W-1:0]      w_aw_idx;
  logic                  w_aw_ok;
  logic [IDX_W-1:0]      w_ar_idx;
  logic                  w_ar_ok;
  logic                  w_aw_hs;
  logic                  w_w_hs;
  logic                  w_ar_hs;
  logic                  w_wr_fire;
  logic [IDX_W-1:0]      w_wr_idx;
  logic                  w_wr_ok;
  logic [DATA_WIDTH-1:0] w_wr_data;
  logic [STRB_W-1:0]     w_wr_strb;
  logic [STRB_W-1:0]     w_in_strb;

`ifdef AXI4L_WSTRB_EN
  assign w_in_strb = s_axi_wstrb;
`else
  assign w_in_strb = '1;
`endif

  axi4_lite_addr_decode #(
    .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH), .NUM_REGS(NUM_REGS)
  ) u_aw_decode (
    .i_addr(s_axi_awaddr), .o_idx_c(w_aw_idx), .o_in_range_c(w_aw_ok)
  );

  axi4_lite_addr_decode #(
    .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH), .NUM_REGS(NUM_REGS)
  ) u_ar_decode (
    .i_addr(s_axi_araddr), .o_idx_c(w_ar_idx), .o_in_range_c(w_ar_ok)
  );

  assign w_aw_hs = s_axi_awvalid & r_awready;
  assign w_w_hs  = s_axi_wvalid  & r_wready;
  assign w_ar_hs = s_axi_arvalid & r_arready;

  // Write commits on the edge where the second of AW/W is accepted; held halves come from r_*.
  assign w_wr_fire = ((r_wstate == W_IDLE)      && w_aw_hs && w_w_hs) ||
                     ((r_wstate == W_HAVE_ADDR) && w_w_hs) ||
                     ((r_wstate == W_HAVE_DATA) && w_aw_hs);
  assign w_wr_idx  = (r_wstate == W_HAVE_ADDR) ? r_aw_idx : w_aw_idx;
  assign w_wr_ok   = (r_wstate == W_HAVE_ADDR) ? r_aw_ok  : w_aw_ok;
  assign w_wr_data = (r_wstate == W_HAVE_DATA) ? r_wdata  : s_axi_wdata;
  assign w_wr_strb = (r_wstate == W_HAVE_DATA) ? r_wstrb  : w_in_strb;

  // Write channel FSM
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_wstate  <= W_IDLE;
      r_awready <= 1'b0;
      r_wready  <= 1'b0;
      r_bvalid  <= 1'b0;
      r_bresp   <= OKAY;
      r_aw_idx  <= '0;
      r_aw_ok   <= 1'b0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
    end else begin
      case (r_wstate)
        W_IDLE: begin
          r_awready <= 1'b1;
          r_wready  <= 1'b1;
          if (w_wr_fire) begin
            r_wstate  <= W_RESP;
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            r_bvalid  <= 1'b1;
            r_bresp   <= range_resp(w_wr_ok);
          end else if (w_aw_hs) begin
            r_wstate  <= W_HAVE_ADDR;
            r_aw_idx  <= w_aw_idx;
            r_aw_ok   <= w_aw_ok;
            r_awready <= 1'b0;
          end else if (w_w_hs) begin
            r_wstate <= W_HAVE_DATA;
            r_wdata  <= s_axi_wdata;
            r_wstrb  <= w_in_strb;
            r_wready <= 1'b0;
          end
        end
        W_HAVE_ADDR, W_HAVE_DATA: begin
          if (w_wr_fire) begin
            r_wstate  <= W_RESP;
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            r_bvalid  <= 1'b1;
            r_bresp   <= range_resp(w_wr_ok);
          end
        end
        W_RESP: begin
          if (s_axi_bready) begin
            r_wstate  <= W_IDLE;
            r_bvalid  <= 1'b0;
            r_awready <= 1'b1;
            r_wready  <= 1'b1;
          end
        end
        default: r_wstate <= W_IDLE;
      endcase
    end
  end

  // Register storage with byte-lane enables
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      for (int i = 0; i < int'(NUM_REGS); i++) r_regs[i] <= '0;
    end else if (w_wr_fire && w_wr_ok) begin
      for (int b = 0; b < int'(STRB_W); b++) begin
        if (w_wr_strb[b]) r_regs[w_wr_idx][8*b +: 8] <= w_wr_data[8*b +: 8];
      end
    end
  end

  // Read channel FSM; r_regs is sampled before any same-edge write lands
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_rstate  <= R_IDLE;
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rresp   <= OKAY;
      r_rdata   <= '0;
    end else begin
      case (r_rstate)
        R_IDLE: begin
          r_arready <= 1'b1;
          if (w_ar_hs) begin
            r_rstate  <= R_RESP;
            r_arready <= 1'b0;
            r_rvalid  <= 1'b1;
            r_rdata   <= w_ar_ok ? r_regs[w_ar_idx] : '0;
            r_rresp   <= range_resp(w_ar_ok);
          end
        end
        R_RESP: begin
          if (s_axi_rready) begin
            r_rstate  <= R_IDLE;
            r_rvalid  <= 1'b0;
            r_arready <= 1'b1;
          end
        end
        default: r_rstate <= R_IDLE;
      endcase
    end
  end

  for (genvar k = 0; k < int'(NUM_REGS); k++) begin : g_reg_out
    assign reg_out[k*DATA_WIDTH +: DATA_WIDTH] = r_regs[k];
  end

  assign s_axi_awready = r_awready;
  assign s_axi_wready  = r_wready;
  assign s_axi_bvalid  = r_bvalid;
  assign s_axi_bresp   = r_bresp;
  assign s_axi_arready = r_arready;
  assign s_axi_rvalid  = r_rvalid;
  assign s_axi_rresp   = r_rresp;
  assign s_axi_rdata   = r_rdata;

endmodule

// File: tb/tb_axi4_lite_regbank.sv
// Scoreboard bench for axi4_lite_regbank: stimulus pushes expected B/R responses, a monitor pops and compares.
module tb_axi4_lite_regbank;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 32;
  localparam int unsigned NR = 8;
  localparam logic [1:0] R_OK  = 2'b00;
  localparam logic [1:0] R_ERR = 2'b10;

  logic            aclk;
  logic            aresetn;
  logic [AW-1:0]   s_axi_awaddr;
  logic            s_axi_awvalid;
  logic            s_axi_awready;
  logic [DW-1:0]   s_axi_wdata;
`ifdef AXI4L_WSTRB_EN
  logic [DW/8-1:0] s_axi_wstrb;
`endif
  logic            s_axi_wvalid;
  logic            s_axi_wready;
  logic [1:0]      s_axi_bresp;
  logic            s_axi_bvalid;
  logic            s_axi_bready;
  logic [AW-1:0]   s_axi_araddr;
  logic            s_axi_arvalid;
  logic            s_axi_arready;
  logic [DW-1:0]   s_axi_rdata;
  logic [1:0]      s_axi_rresp;
  logic            s_axi_rvalid;
  logic            s_axi_rready;
  logic [NR*DW-1:0] reg_out;

  axi4_lite_regbank #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REGS(NR)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata),
`ifdef AXI4L_WSTRB_EN
    .s_axi_wstrb(s_axi_wstrb),
`endif
    .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
    .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
    .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp), .s_axi_rvalid(s_axi_rvalid),
    .s_axi_rready(s_axi_rready), .reg_out(reg_out)
  );

  typedef struct packed {
    logic [DW-1:0] data;
    logic [1:0]    resp;
  } rexp_t;

  logic [1:0]    exp_b [$];
  rexp_t         exp_r [$];
  logic [DW-1:0] mdl [NR];
  int            n_cmp = 0;
  int            n_bad = 0;

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: a response handshakes on the next edge when valid and ready are both high here.
  always @(negedge aclk) begin
    if (aresetn && s_axi_bvalid && s_axi_bready) begin
      if (exp_b.size() == 0) check("b_unexpected", 64'(s_axi_bvalid), 64'(0));
      else check("bresp", 64'(s_axi_bresp), 64'(exp_b.pop_front()));
    end
    if (aresetn && s_axi_rvalid && s_axi_rready) begin
      if (exp_r.size() == 0) check("r_unexpected", 64'(s_axi_rvalid), 64'(0));
      else begin
        rexp_t e;
        e = exp_r.pop_front();
        check("rdata", 64'(s_axi_rdata), 64'(e.data));
        check("rresp", 64'(s_axi_rresp), 64'(e.resp));
      end
    end
  end

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic check_regs(input string tag);
    for (int k = 0; k < int'(NR); k++)
      check($sformatf("%s reg_out[%0d]", tag, k), 64'(reg_out[k*DW +: DW]), 64'(mdl[k]));
  endtask

  // Drives AW at cycle t_aw and W at cycle t_w (relative), returns once both are accepted.
  task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input int t_aw, input int t_w, input logic [1:0] resp);
    bit aw_done = 0, w_done = 0, aw_hs, w_hs;
    logic unused_strb;
    unused_strb = ^strb;
    exp_b.push_back(resp);
    for (int cyc = 0; cyc < 40 && !(aw_done && w_done); cyc++) begin
      s_axi_awaddr  = addr;
      s_axi_wdata   = data;
`ifdef AXI4L_WSTRB_EN
      s_axi_wstrb   = strb;
`endif
      s_axi_awvalid = !aw_done && (cyc >= t_aw);
      s_axi_wvalid  = !w_done && (cyc >= t_w);
      @(negedge aclk);
      aw_hs = s_axi_awvalid && s_axi_awready;
      w_hs  = s_axi_wvalid && s_axi_wready;
      tick();
      if (aw_hs) aw_done = 1;
      if (w_hs)  w_done  = 1;
    end
    s_axi_awvalid = 1'b0;
    s_axi_wvalid  = 1'b0;
    if (!(aw_done && w_done)) check("write_accept_timeout", 64'({aw_done, w_done}), 64'(2'b11));
  endtask

  task automatic wait_b();
    for (int i = 0; i < 20 && exp_b.size() != 0; i++) tick();
    if (exp_b.size() != 0) begin
      check("bresp_timeout", 64'(exp_b.size()), 64'(0));
      exp_b.delete();
    end
  endtask

  task automatic write_full(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input int t_aw, input int t_w, input logic [1:0] resp);
    do_write(addr, data, strb, t_aw, t_w, resp);
    wait_b();
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] resp);
    bit hs = 0;
    exp_r.push_back('{data: data, resp: resp});
    s_axi_araddr  = addr;
    s_axi_arvalid = 1'b1;
    for (int i = 0; i < 40 && !hs; i++) begin
      @(negedge aclk);
      hs = s_axi_arvalid && s_axi_arready;
      tick();
    end
    s_axi_arvalid = 1'b0;
    if (!hs) check("read_accept_timeout", 64'(hs), 64'(1));
    for (int i = 0; i < 20 && exp_r.size() != 0; i++) tick();
    if (exp_r.size() != 0) begin
      check("rdata_timeout", 64'(exp_r.size()), 64'(0));
      exp_r.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, n_cmp=%0d expected completion", n_cmp);
    $fatal(1, "watchdog");
  end

  initial begin
    aresetn = 1'b0;
    s_axi_awaddr = '0; s_axi_awvalid = 1'b0;
    s_axi_wdata = '0;  s_axi_wvalid = 1'b0;
`ifdef AXI4L_WSTRB_EN
    s_axi_wstrb = '0;
`endif
    s_axi_araddr = '0; s_axi_arvalid = 1'b0;
    s_axi_bready = 1'b1; s_axi_rready = 1'b1;
    for (int k = 0; k < int'(NR); k++) mdl[k] = '0;

    // Reset state
    repeat (3) tick();
    @(negedge aclk);
    check("rst awready", 64'(s_axi_awready), 64'(0));
    check("rst wready",  64'(s_axi_wready),  64'(0));
    check("rst arready", 64'(s_axi_arready), 64'(0));
    check("rst bvalid",  64'(s_axi_bvalid),  64'(0));
    check("rst rvalid",  64'(s_axi_rvalid),  64'(0));
    check("rst bresp",   64'(s_axi_bresp),   64'(0));
    check("rst rresp",   64'(s_axi_rresp),   64'(0));
    check("rst rdata",   64'(s_axi_rdata),   64'(0));
    check_regs("rst");
    tick();
    aresetn = 1'b1;
    tick();
    check("post-rst awready", 64'(s_axi_awready), 64'(1));
    check("post-rst wready",  64'(s_axi_wready),  64'(1));
    check("post-rst arready", 64'(s_axi_arready), 64'(1));

    // Reads after reset
    do_read(32'h00, 32'h0, R_OK);
    do_read(32'h04, 32'h0, R_OK);

    // Basic writes: same-cycle AW/W and AW one cycle ahead
    write_full(32'h00, 32'hDEAD_BEEF, 4'hF, 0, 0, R_OK); mdl[0] = 32'hDEAD_BEEF;
    write_full(32'h04, 32'hADAD_ABAB, 4'hF, 0, 1, R_OK); mdl[1] = 32'hADAD_ABAB;
    do_read(32'h00, 32'hDEAD_BEEF, R_OK);
    do_read(32'h04, 32'hADAD_ABAB, R_OK);
    do_read(32'h07, 32'hADAD_ABAB, R_OK);
    write_full(32'h1C, 32'h5A5A_0001, 4'hF, 0, 0, R_OK); mdl[7] = 32'h5A5A_0001;
    do_read(32'h1C, 32'h5A5A_0001, R_OK);
    check_regs("basic");

    // Out-of-range accesses
    write_full(32'h20, 32'h1234_5678, 4'hF, 0, 0, R_ERR);
    check_regs("oor");
    do_read(32'h20, 32'h0, R_ERR);
    do_read(32'h8000_0000, 32'h0, R_ERR);

    // W two cycles ahead of AW, bready held low five cycles
    s_axi_bready = 1'b0;
    do_write(32'h08, 32'hCAFE_F00D, 4'hF, 2, 0, R_OK);
    for (int i = 0; i < 5; i++) begin
      @(negedge aclk);
      check("bvalid held", 64'(s_axi_bvalid), 64'(1));
      check("bresp held",  64'(s_axi_bresp),  64'(R_OK));
      check("awready in resp", 64'(s_axi_awready), 64'(0));
      tick();
    end
    s_axi_bready = 1'b1;
    wait_b();
    @(negedge aclk);
    check("bvalid dropped", 64'(s_axi_bvalid), 64'(0));
    tick();
    mdl[2] = 32'hCAFE_F00D;
    do_read(32'h08, 32'hCAFE_F00D, R_OK);
    write_full(32'h0C, 32'h0BAD_CAFE, 4'hF, 0, 2, R_OK); mdl[3] = 32'h0BAD_CAFE;
    do_read(32'h0C, 32'h0BAD_CAFE, R_OK);

    // Read colliding with a write to the same register returns the old value
    write_full(32'h10, 32'h1111_1111, 4'hF, 0, 0, R_OK);
    fork
      do_write(32'h10, 32'h2222_2222, 4'hF, 0, 0, R_OK);
      do_read(32'h10, 32'h1111_1111, R_OK);
    join
    wait_b();
    mdl[4] = 32'h2222_2222;
    do_read(32'h10, 32'h2222_2222, R_OK);
    check_regs("collide");

`ifdef AXI4L_WSTRB_EN
    write_full(32'h14, 32'hFFFF_FFFF, 4'hF, 0, 0, R_OK);
    write_full(32'h14, 32'h1234_5678, 4'b0011, 0, 0, R_OK);
    do_read(32'h14, 32'hFFFF_5678, R_OK);
    write_full(32'h14, 32'h0000_0000, 4'b0000, 0, 0, R_OK);
    do_read(32'h14, 32'hFFFF_5678, R_OK);
    mdl[5] = 32'hFFFF_5678;
    check_regs("wstrb");
`endif

    // Reset while holding only the write address
    s_axi_awaddr  = 32'h18;
    s_axi_awvalid = 1'b1;
    tick();
    s_axi_awvalid = 1'b0;
    check("aw held, awready low", 64'(s_axi_awready), 64'(0));
    aresetn = 1'b0;
    for (int k = 0; k < int'(NR); k++) mdl[k] = '0;
    for (int i = 0; i < 2; i++) begin
      @(negedge aclk);
      check("rst bvalid mid", 64'(s_axi_bvalid), 64'(0));
      tick();
    end
    aresetn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge aclk);
      check("no b after abort", 64'(s_axi_bvalid), 64'(0));
      tick();
    end
    check_regs("abort");
    do_read(32'h18, 32'h0, R_OK);
    write_full(32'h18, 32'h0000_CAFE, 4'hF, 0, 0, R_OK); mdl[6] = 32'h0000_CAFE;
    do_read(32'h18, 32'h0000_CAFE, R_OK);
    tick();
    check_regs("final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/axi4_lite_regbank.md
AXI4_LITE_REGBANK -- requirements
Module: axi4_lite_regbank

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, giving the data bus and register width (32 or 64).
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 32, giving the address bus width.
REQ-003 The block SHALL have parameter NUM_REGS, default 8, giving the register count (power of two, 2..256).
REQ-004 The block SHALL have one clock and a synchronous, active-low reset, on the ports listed first below.
REQ-005 aclk  in  1  clock.
REQ-006 aresetn  in  1  synchronous active-low reset.
REQ-007 s_axi_awaddr  in  ADDR_WIDTH  write address.
REQ-008 s_axi_awvalid / s_axi_awready  in / out  1  write-address handshake.
REQ-009 s_axi_wdata  in  DATA_WIDTH  write data.
REQ-010 s_axi_wstrb  in  DATA_WIDTH/8  byte strobes; present only with AXI4L_WSTRB_EN.
REQ-011 s_axi_wvalid / s_axi_wready  in / out  1  write-data handshake.
REQ-012 s_axi_bresp  out  2  write response.
REQ-013 s_axi_bvalid / s_axi_bready  out / in  1  write-response handshake.
REQ-014 s_axi_araddr  in  ADDR_WIDTH  read address.
REQ-015 s_axi_arvalid / s_axi_arready  in / out  1  read-address handshake.
REQ-016 s_axi_rdata  out  DATA_WIDTH  read data.
REQ-017 s_axi_rresp  out  2  read response.
REQ-018 s_axi_rvalid / s_axi_rready  out / in  1  read-data handshake.
REQ-019 reg_out  out  NUM_REGS*DATA_WIDTH  flat register contents; register k occupies slice k.

Function
REQ-020 Register index SHALL be addr[log2(NUM_REGS)+log2(DATA_WIDTH/8)-1 : log2(DATA_WIDTH/8)]; address low byte-offset bits are ignored.
REQ-021 An address whose bits above the index field are non-zero is out of range: response SLVERR (2'b10), no register write, rdata 0.
REQ-022 Write FSM states: W_IDLE, W_HAVE_ADDR, W_HAVE_DATA, W_RESP.
REQ-023 awready is high in W_IDLE and W_HAVE_DATA; wready is high in W_IDLE and W_HAVE_ADDR; AW and W are accepted in either order or in the same cycle.
REQ-024 Once both AW and W are held, the register is updated and bvalid rises in the next cycle (W_RESP); bresp is OKAY (2'b00) or SLVERR.
REQ-025 In W_RESP, bvalid and bresp stay stable until bready; no new AW or W is accepted until then; on bready the FSM returns to W_IDLE.
REQ-026 Read FSM states: R_IDLE, R_RESP; arready is high only in R_IDLE.
REQ-027 rdata and rresp are registered; rvalid rises one cycle after the AR handshake and holds with stable data until rready.
REQ-028 A read and a write to the same register whose register update coincides with the AR handshake SHALL return the pre-write value.
REQ-029 reg_out reflects a write one cycle after the write is performed.

Reset
REQ-030 While aresetn is low at a rising edge: all registers are 0; awready, wready, arready, bvalid and rvalid are 0; bresp, rresp and rdata are 0; both FSMs are in IDLE.
REQ-031 Reset asserted mid-transaction aborts the transaction without a response; a pending write is discarded.
REQ-032 awready, wready and arready rise in the first cycle after aresetn goes high.

Configuration
REQ-033 With macro AXI4L_WSTRB_EN defined, s_axi_wstrb exists and only byte lanes with a set strobe are written; wstrb all-zero writes nothing but still returns OKAY.
REQ-034 Without AXI4L_WSTRB_EN, the port is absent and every accepted write updates the full word.

Structure
REQ-035 Package axi4_lite_pkg SHALL hold the resp_t enum (OKAY, EXOKAY, SLVERR, DECERR) and the write/read FSM state typedefs.
REQ-036 A sub-module axi4_lite_addr_decode SHALL be instantiated for each of the AW and AR paths, producing the register index and the in-range flag.

Verification
REQ-037 Read 0x00 and 0x04 after reset -> 0x0000_0000, rresp OKAY.
REQ-038 Write 0xDEAD_BEEF to 0x00 and 0xADAD_ABAB to 0x04, then read back -> same values, bresp OKAY; reg_out slices match.
REQ-039 With NUM_REGS=8, write to 0x20 -> bresp SLVERR and no register changes; read 0x20 -> rdata 0, rresp SLVERR.
REQ-040 Present W two cycles before AW with bready held low for 5 cycles -> a single bvalid, held stable, and write completes; then AW-before-W also passes.
REQ-041 With AXI4L_WSTRB_EN, write 0x1234_5678 with wstrb 4'b0011 over 0xFFFF_FFFF -> readback 0xFFFF_5678.
REQ-042 Assert reset during W_HAVE_ADDR, then release -> no bvalid, register remains 0, next write succeeds.
